// File: rtl/hans_cpu.sv
// Multi-cycle 32-bit load/store core with a 64-entry register file and word-addressed I/D ports.
// Latency: 3 cycles for ALU/branch/jump ops, 5 cycles for LD/ST when acknowledges are tied high.
// Backpressure: a low acknowledge parks the core in its wait state with request and address held stable.

module hans_cpu_regfile (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [5:0]  readAddrD,
    input  logic [5:0]  readAddrA,
    input  logic [5:0]  readAddrB,
    output logic [31:0] readDataD,
    output logic [31:0] readDataA,
    output logic [31:0] readDataB,
    input  logic        writeEn,
    input  logic [5:0]  writeAddr,
    input  logic [31:0] writeData
);
    logic [31:0] registers [64];

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < 64; i++) registers[i] <= '0;
        end else if (writeEn && writeAddr != 6'd0) begin
            registers[writeAddr] <= writeData;
        end
    end

    // r0 is hardwired to zero on every read port
    assign readDataD = (readAddrD == 6'd0) ? 32'd0 : registers[readAddrD];
    assign readDataA = (readAddrA == 6'd0) ? 32'd0 : registers[readAddrA];
    assign readDataB = (readAddrB == 6'd0) ? 32'd0 : registers[readAddrB];
endmodule

module hans_cpu (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [31:0] Instruktion,
    input  logic        InstruktionGeladen,
    input  logic [31:0] DatenRein,
    input  logic        DatenGeladen,
    input  logic        DatenGespeichert,
    output logic [31:0] InstruktionAdresse,
    output logic        LeseInstruktion,
    output logic [31:0] DatenAdresse,
    output logic [31:0] DatenRaus,
    output logic        LeseDaten,
    output logic        SchreibeDaten
);
    localparam logic [5:0] OP_ADD  = 6'h01;
    localparam logic [5:0] OP_SUB  = 6'h02;
    localparam logic [5:0] OP_AND  = 6'h03;
    localparam logic [5:0] OP_OR   = 6'h04;
    localparam logic [5:0] OP_XOR  = 6'h05;
    localparam logic [5:0] OP_SHL  = 6'h06;
    localparam logic [5:0] OP_SHR  = 6'h07;
    localparam logic [5:0] OP_SLT  = 6'h08;
    localparam logic [5:0] OP_ADDI = 6'h09;
    localparam logic [5:0] OP_LUI  = 6'h0A;
    localparam logic [5:0] OP_LD   = 6'h0B;
    localparam logic [5:0] OP_ST   = 6'h0C;
    localparam logic [5:0] OP_BEQ  = 6'h0D;
    localparam logic [5:0] OP_BNE  = 6'h0E;
    localparam logic [5:0] OP_JMP  = 6'h0F;
    localparam logic [5:0] OP_HALT = 6'h3F;

    typedef enum logic [2:0] {
        FETCH, IWAIT, EXEC, MEM, DWAIT, SWAIT, HALT
    } stateT;

    stateT       state, stateNext;
    logic [31:0] pc, pcNext;
    logic [31:0] ir, irNext;
    logic [31:0] effAddr, effAddrNext;
    logic [31:0] storeData, storeDataNext;

    logic [5:0]  op, rd, ra, rb;
    logic [31:0] imm;
    logic [31:0] rdVal, raVal, rbVal;
    logic [31:0] aluResult;
    logic        aluWrites;
    logic        regWe;
    logic [31:0] regWdata;
    logic [31:0] pcPlusOne;

    assign op        = ir[31:26];
    assign rd        = ir[25:20];
    assign ra        = ir[19:14];
    assign rb        = ir[13:8];
    assign imm       = {{18{ir[13]}}, ir[13:0]};
    assign pcPlusOne = pc + 32'd1;

    hans_cpu_regfile Register (
        .Clock     (Clock),
        .Reset     (Reset),
        .readAddrD (rd),
        .readAddrA (ra),
        .readAddrB (rb),
        .readDataD (rdVal),
        .readDataA (raVal),
        .readDataB (rbVal),
        .writeEn   (regWe),
        .writeAddr (rd),
        .writeData (regWdata)
    );

    always_comb begin
        aluResult = 32'd0;
        aluWrites = 1'b1;
        case (op)
            OP_ADD:  aluResult = raVal + rbVal;
            OP_SUB:  aluResult = raVal - rbVal;
            OP_AND:  aluResult = raVal & rbVal;
            OP_OR:   aluResult = raVal | rbVal;
            OP_XOR:  aluResult = raVal ^ rbVal;
            OP_SHL:  aluResult = raVal << rbVal[4:0];
            OP_SHR:  aluResult = raVal >> rbVal[4:0];
            OP_SLT:  aluResult = {31'd0, $signed(raVal) < $signed(rbVal)};
            OP_ADDI: aluResult = raVal + imm;
            OP_LUI:  aluResult = {ir[13:0], 18'd0};
            default: aluWrites = 1'b0;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state     <= FETCH;
            pc        <= '0;
            ir        <= '0;
            effAddr   <= '0;
            storeData <= '0;
        end else begin
            state     <= stateNext;
            pc        <= pcNext;
            ir        <= irNext;
            effAddr   <= effAddrNext;
            storeData <= storeDataNext;
        end
    end

    always_comb begin
        stateNext     = state;
        pcNext        = pc;
        irNext        = ir;
        effAddrNext   = effAddr;
        storeDataNext = storeData;
        regWe         = 1'b0;
        regWdata      = aluResult;
        case (state)
            FETCH: stateNext = IWAIT;
            IWAIT: begin
                if (InstruktionGeladen) begin
                    irNext    = Instruktion;
                    stateNext = EXEC;
                end
            end
            EXEC: begin
                stateNext = FETCH;
                pcNext    = pcPlusOne;
                case (op)
                    OP_LD, OP_ST: begin
                        // address and store data are frozen here so the RAM sees stable values through the wait
                        effAddrNext   = raVal + imm;
                        storeDataNext = rdVal;
                        pcNext        = pc;
                        stateNext     = MEM;
                    end
                    OP_BEQ:  if (rdVal == raVal) pcNext = pcPlusOne + imm;
                    OP_BNE:  if (rdVal != raVal) pcNext = pcPlusOne + imm;
                    OP_JMP:  pcNext = raVal + imm;
                    OP_HALT: begin
                        pcNext    = pc;
                        stateNext = HALT;
                    end
                    default: regWe = aluWrites;
                endcase
            end
            MEM: stateNext = (op == OP_LD) ? DWAIT : SWAIT;
            DWAIT: begin
                if (DatenGeladen) begin
                    regWe     = 1'b1;
                    regWdata  = DatenRein;
                    pcNext    = pcPlusOne;
                    stateNext = FETCH;
                end
            end
            SWAIT: begin
                if (DatenGespeichert) begin
                    pcNext    = pcPlusOne;
                    stateNext = FETCH;
                end
            end
            HALT:    stateNext = HALT;
            default: stateNext = FETCH;
        endcase
    end

    // strobes are gated by reset so nothing is requested or written while it is held low
    assign InstruktionAdresse = pc;
    assign DatenAdresse       = effAddr;
    assign DatenRaus          = storeData;
    assign LeseInstruktion    = Reset && (state == FETCH || state == IWAIT);
    assign LeseDaten          = Reset && ((state == MEM && op == OP_LD) || state == DWAIT);
    assign SchreibeDaten      = Reset && state == MEM && op == OP_ST;
endmodule

// File: tb/tb_hans_cpu.sv
// Directed program run against hans_cpu with a registered-read instruction/data RAM model.

module tb_hans_cpu;
    logic        Clock = 1'b0;
    logic        Reset;
    logic [31:0] Instruktion;
    logic        InstruktionGeladen;
    logic [31:0] DatenRein;
    logic        DatenGeladen;
    logic        DatenGespeichert;
    logic [31:0] InstruktionAdresse;
    logic        LeseInstruktion;
    logic [31:0] DatenAdresse;
    logic [31:0] DatenRaus;
    logic        LeseDaten;
    logic        SchreibeDaten;

    int compared   = 0;
    int mismatched = 0;

    logic [31:0] imem [256];
    logic [31:0] dmem [256] = '{default: 32'd0};
    int writeCount = 0;
    int writeRun   = 0;
    int writeRunMax = 0;

    hans_cpu dut (
        .Clock              (Clock),
        .Reset              (Reset),
        .Instruktion        (Instruktion),
        .InstruktionGeladen (InstruktionGeladen),
        .DatenRein          (DatenRein),
        .DatenGeladen       (DatenGeladen),
        .DatenGespeichert   (DatenGespeichert),
        .InstruktionAdresse (InstruktionAdresse),
        .LeseInstruktion    (LeseInstruktion),
        .DatenAdresse       (DatenAdresse),
        .DatenRaus          (DatenRaus),
        .LeseDaten          (LeseDaten),
        .SchreibeDaten      (SchreibeDaten)
    );

    always #5 Clock = ~Clock;

    always @(posedge Clock) begin
        Instruktion <= imem[InstruktionAdresse[7:0]];
        DatenRein   <= dmem[DatenAdresse[7:0]];
        if (SchreibeDaten) begin
            dmem[DatenAdresse[7:0]] <= DatenRaus;
            writeCount = writeCount + 1;
            writeRun   = writeRun + 1;
            if (writeRun > writeRunMax) writeRunMax = writeRun;
        end else begin
            writeRun = 0;
        end
    end

    function automatic logic [31:0] encI(input logic [5:0] op, input logic [5:0] rd,
                                         input logic [5:0] ra, input int imm);
        logic [31:0] v;
        v = imm;
        return {op, rd, ra, v[13:0]};
    endfunction

    function automatic logic [31:0] encR(input logic [5:0] op, input logic [5:0] rd,
                                         input logic [5:0] ra, input logic [5:0] rb);
        return {op, rd, ra, rb, 8'h00};
    endfunction

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    function automatic int nonZeroRegs();
        int n = 0;
        for (int i = 0; i < 64; i++) if (dut.Register.registers[i] !== 32'd0) n++;
        return n;
    endfunction

    logic [31:0] expWord [13];

    initial begin
        int found;
        int quiet;
        int bad;

        for (int i = 0; i < 256; i++) imem[i] = 32'd0;
        imem[0]  = encI(6'h09, 6'd1, 6'd0, 5);
        imem[1]  = encI(6'h09, 6'd2, 6'd0, -3);
        imem[2]  = encR(6'h01, 6'd3, 6'd1, 6'd2);
        imem[3]  = encI(6'h0C, 6'd3, 6'd0, 0);
        imem[4]  = encR(6'h02, 6'd4, 6'd2, 6'd1);
        imem[5]  = encR(6'h08, 6'd5, 6'd4, 6'd0);
        imem[6]  = encI(6'h09, 6'd8, 6'd0, 28);
        imem[7]  = encR(6'h07, 6'd6, 6'd4, 6'd8);
        imem[8]  = encI(6'h0C, 6'd4, 6'd0, 1);
        imem[9]  = encI(6'h0C, 6'd5, 6'd0, 2);
        imem[10] = encI(6'h0C, 6'd6, 6'd0, 3);
        imem[11] = encI(6'h09, 6'd1, 6'd0, 10);
        imem[12] = encI(6'h09, 6'd1, 6'd1, -1);
        imem[13] = encI(6'h0C, 6'd1, 6'd0, 4);
        imem[14] = encI(6'h0E, 6'd1, 6'd0, -3);
        imem[15] = encI(6'h09, 6'd9, 6'd0, 32'h1234);
        imem[16] = encI(6'h0C, 6'd9, 6'd0, 5);
        imem[17] = encI(6'h0B, 6'd7, 6'd0, 5);
        imem[18] = encI(6'h0C, 6'd7, 6'd0, 6);
        imem[19] = encI(6'h09, 6'd0, 6'd0, 7);
        imem[20] = encI(6'h0C, 6'd0, 6'd0, 7);
        imem[21] = encI(6'h0A, 6'd10, 6'd0, 32'h2001);
        imem[22] = encI(6'h0C, 6'd10, 6'd0, 8);
        imem[23] = encR(6'h05, 6'd11, 6'd9, 6'd3);
        imem[24] = encR(6'h06, 6'd12, 6'd3, 6'd8);
        imem[25] = encI(6'h0C, 6'd11, 6'd0, 9);
        imem[26] = encI(6'h0C, 6'd12, 6'd0, 10);
        imem[27] = encI(6'h0D, 6'd0, 6'd0, 1);
        imem[28] = encI(6'h0C, 6'd9, 6'd0, 11);
        imem[29] = encI(6'h09, 6'd13, 6'd0, 31);
        imem[30] = encI(6'h0F, 6'd0, 6'd13, 2);
        imem[31] = encI(6'h0C, 6'd9, 6'd0, 12);
        imem[32] = encI(6'h0C, 6'd9, 6'd0, 12);
        imem[33] = encI(6'h10, 6'd14, 6'd1, 9);
        imem[34] = {6'h3F, 26'd0};

        expWord = '{32'h00000002, 32'hFFFFFFF8, 32'h00000001, 32'h0000000F, 32'h00000000,
                    32'h00001234, 32'h00001234, 32'h00000000, 32'h80040000, 32'h00001236,
                    32'h20000000, 32'h00000000, 32'h00000000};

        Reset              = 1'b0;
        InstruktionGeladen = 1'b1;
        DatenGeladen       = 1'b0;
        DatenGespeichert   = 1'b1;

        repeat (5) @(negedge Clock);
        check("reset_iaddr", InstruktionAdresse, 32'd0);
        check("reset_daddr", DatenAdresse, 32'd0);
        check("reset_dout", DatenRaus, 32'd0);
        check("reset_rdi", {31'd0, LeseInstruktion}, 32'd0);
        check("reset_rdd", {31'd0, LeseDaten}, 32'd0);
        check("reset_wr", {31'd0, SchreibeDaten}, 32'd0);

        Reset = 1'b1;
        #1;
        check("first_iaddr", InstruktionAdresse, 32'd0);
        check("first_rdi", {31'd0, LeseInstruktion}, 32'd1);
        check("regs_zero", nonZeroRegs(), 32'd0);

        // LD at word 17 meets a held-low data acknowledge
        found = 0;
        for (int c = 0; c < 2000 && found == 0; c++) begin
            @(negedge Clock);
            if (LeseDaten) found = 1;
        end
        check("ld_seen", found, 32'd1);
        check("ld_addr", DatenAdresse, 32'd5);
        for (int c = 0; c < 4; c++) begin
            @(negedge Clock);
            check("dwait_rdd", {31'd0, LeseDaten}, 32'd1);
            check("dwait_addr", DatenAdresse, 32'd5);
            check("dwait_pc", InstruktionAdresse, 32'd17);
        end
        DatenGeladen = 1'b1;

        quiet = 0;
        for (int c = 0; c < 3000 && quiet < 5; c++) begin
            @(negedge Clock);
            if (!LeseInstruktion && !LeseDaten && !SchreibeDaten) quiet++;
            else quiet = 0;
        end
        check("halt_reached", quiet, 32'd5);
        check("halt_pc", InstruktionAdresse, 32'd34);
        bad = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge Clock);
            if (InstruktionAdresse !== 32'd34 || LeseInstruktion || LeseDaten || SchreibeDaten) bad++;
        end
        check("halt_frozen", bad, 32'd0);

        for (int i = 0; i < 13; i++) check($sformatf("word%0d", i), dmem[i], expWord[i]);
        check("write_count", writeCount, 32'd20);
        check("write_pulse", writeRunMax, 32'd1);
        check("r0_zero", dut.Register.registers[0], 32'd0);
        check("r7_load", dut.Register.registers[7], 32'h00001234);
        check("r1_loop", dut.Register.registers[1], 32'd0);

        Reset = 1'b0;
        #1;
        check("rst2_iaddr", InstruktionAdresse, 32'd0);
        check("rst2_daddr", DatenAdresse, 32'd0);
        check("rst2_dout", DatenRaus, 32'd0);
        check("rst2_strobes", {29'd0, LeseInstruktion, LeseDaten, SchreibeDaten}, 32'd0);
        check("rst2_regs", nonZeroRegs(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/hans_cpu.md
# hans_cpu

Multi-cycle 32-bit load/store processor core for the Hans system, with a 64-entry register file and separate instruction and data word-memory ports. It connects to external synchronous RAMs (256 × 32-bit words in the system bench). Each memory read takes 1 cycle: the address is captured on a clock edge and the data is valid the following cycle. Each access uses a request/acknowledge handshake.

## Interface
- No parameters.
- Clock  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Instruktion  in  32  instruction word returned by the instruction RAM.
- InstruktionGeladen  in  1  instruction-read acknowledge.
- DatenRein  in  32  load data returned by the data RAM.
- DatenGeladen  in  1  data-read acknowledge.
- DatenGespeichert  in  1  data-write acknowledge.
- InstruktionAdresse  out  32  word address of the instruction (the PC).
- LeseInstruktion  out  1  instruction-read request.
- DatenAdresse  out  32  data word address.
- DatenRaus  out  32  store data.
- LeseDaten  out  1  data-read request.
- SchreibeDaten  out  1  data-write strobe (RAM write enable).

## Operation
- Addresses are word addresses. The PC increments by 1 and wraps modulo 2^32; the RAM decodes the low address bits.
- Register file: 64 × 32-bit registers, instance named Register, array named registers. r0 always reads 0 and writes to it are discarded.
- Instruction fields:
  - op = [31:26], rd = [25:20], ra = [19:14], rb = [13:8].
  - imm = [13:0], sign-extended to 32 bits.
- Register-register ops (rd = f(ra, rb)):
  - 0x01 ADD, 0x02 SUB, 0x03 AND, 0x04 OR, 0x05 XOR: wrap-around arithmetic/logic.
  - 0x06 SHL, 0x07 SHR (logical): shift amount is rb[4:0].
  - 0x08 SLT: rd = 1 if ra < rb as signed values, else 0.
- Immediate and memory ops:
  - 0x09 ADDI: rd = ra + imm.
  - 0x0A LUI: rd = {imm[13:0], 18'b0}.
  - 0x0B LD: rd = mem[ra + imm].
  - 0x0C ST: mem[ra + imm] = rd.
- Control ops:
  - 0x0D BEQ / 0x0E BNE: compare rd with ra; if taken, PC = PC + 1 + imm, else PC = PC + 1.
  - 0x0F JMP: PC = ra + imm.
  - 0x3F HALT: stop until reset.
  - 0x00 and all other opcodes execute as NOP (PC + 1).
- State machine:
  - FETCH: drive InstruktionAdresse = PC, LeseInstruktion = 1. Go to IWAIT.
  - IWAIT: keep InstruktionAdresse = PC and LeseInstruktion = 1. When InstruktionGeladen = 1, latch Instruktion into IR and go to EXEC; otherwise stay.
  - EXEC:
    - ALU, LUI, branch, JMP, NOP: write rd, update PC, go to FETCH.
    - LD, ST: latch the effective address, go to MEM.
    - HALT: go to HALT.
  - MEM, LD: DatenAdresse = EA, LeseDaten = 1. Go to DWAIT.
  - MEM, ST: DatenAdresse = EA, DatenRaus = rd, SchreibeDaten = 1 for this single cycle. Go to SWAIT.
  - DWAIT: hold LeseDaten and DatenAdresse. When DatenGeladen = 1, write DatenRein to rd, PC + 1, go to FETCH.
  - SWAIT: SchreibeDaten = 0, hold the address and data. When DatenGespeichert = 1, PC + 1, go to FETCH.
  - HALT: all strobes 0; stay in HALT until reset.
- Memory contract for the external RAM:
  - Write: Daten[Adresse] <= DatenRein on the clock edge where SchreibenAn = 1.
  - Read: DatenRaus is registered (read captured on the edge, valid the next cycle).

## Timing
- Reset asserted (low):
  - Asynchronously forces PC = 0, IR = 0, all 64 registers = 0, state = FETCH.
  - All outputs 0: InstruktionAdresse, DatenAdresse, DatenRaus, LeseInstruktion, LeseDaten, SchreibeDaten.
- Reset asserted mid-access aborts the access. No write strobe is emitted while reset is active.
- Latency with acknowledges tied high:
  - ALU, LUI, branch, JMP, NOP: 3 cycles.
  - LD: 5 cycles.
  - ST: 5 cycles.
- Acknowledge rules:
  - An acknowledge held low stalls the core indefinitely in the corresponding wait state, with address and request stable.
  - Acknowledges arriving in any other state are ignored.
- The register write and the PC update occur on the same edge that leaves EXEC or the wait state.
- A read of rd, ra or rb in EXEC sees all earlier writes, since there is no pipelining.
- A branch to its own address (imm = -1) loops forever without error.

## Test plan
- Reset (low) for 5 cycles, then release → InstruktionAdresse = 0 and LeseInstruktion = 1 in the first cycle; all registers read 0.
- ADDI r1,r0,5; ADDI r2,r0,-3; ADD r3,r1,r2; ST r3,0(r0) → data word 0 = 0x00000002, written exactly one cycle with SchreibeDaten = 1.
- SUB r4,r2,r1; SLT r5,r4,r0; SHR r6,r4,28 via rb; ST to words 1..3 → values 0xFFFFFFF8, 1, 0x0000000F.
- Loop with r1 = 10, decrement and BNE back, storing the count to word 4 → word 4 = 0 after exit; PC ends at the instruction following the loop.
- ST word 5 = 0x1234 then LD r7 from word 5, store r7 to word 6 → word 6 = 0x00001234. Also: ADDI r0,r0,7 then ST r0 → stores 0.
- Hold DatenGeladen low for 4 cycles during LD → core stays in DWAIT, LeseDaten and DatenAdresse stable. After HALT, PC is frozen and no strobes are asserted for 100 cycles.
